classifier_sequencer: RTL and testbench

- Drives one classifier instance through a batch of images held in on-chip pixel and weight BRAMs.
- Issues memory reads, presents joint pixel/weight beats on the classifier's x/w streams, and holds bias steady on b.
- Collects each hardmax result and reports per-image class plus batch completion.
- Sits between the host-facing control/config registers and the classifier datapath.

---
 rtl/classifier_sequencer_pkg.sv | 19 +
 rtl/classifier_sequencer_if.sv | 28 ++
 rtl/classifier_sequencer_skid.sv | 53 +++++
 rtl/classifier_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_classifier_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/classifier_sequencer_pkg.sv
// Shared widths, default sizing and FSM state encoding for the classifier sequencer.
package classifier_pkg;

    localparam int unsigned CLASS_W          = 4;
    localparam int unsigned PIX_W            = 4;
    localparam int unsigned WVEC_W           = 40;
    localparam int unsigned BEAT_W           = PIX_W + WVEC_W;
    localparam int unsigned DEF_NUM_FEATURES = 160;
    localparam int unsigned DEF_NUM_CLASSES  = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STREAM   = 3'd1,
        WAIT_RES = 3'd2,
        NEXT     = 3'd3,
        FINISH   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/classifier_sequencer_if.sv
// x/w/b/a stream bundle between the sequencer (master) and one classifier (slave).
interface classifier_sequencer_if #(
    parameter int unsigned BIAS_W = classifier_pkg::WVEC_W
);

    logic [classifier_pkg::PIX_W-1:0]   x_tdata;
    logic                               x_tvalid;
    logic                               x_tready;
    logic [classifier_pkg::WVEC_W-1:0]  w_tdata;
    logic                               w_tvalid;
    logic                               w_tready;
    logic [BIAS_W-1:0]                  b_tdata;
    logic                               b_tvalid;
    logic [classifier_pkg::CLASS_W-1:0] a_tdata;
    logic                               a_tvalid;
    logic                               a_tready;

    modport master (
        output x_tdata, x_tvalid, w_tdata, w_tvalid, b_tdata, b_tvalid, a_tready,
        input  x_tready, w_tready, a_tdata, a_tvalid
    );

    modport slave (
        input  x_tdata, x_tvalid, w_tdata, w_tvalid, b_tdata, b_tvalid, a_tready,
        output x_tready, w_tready, a_tdata, a_tvalid
    );

endinterface

// File: rtl/classifier_sequencer_skid.sv
// Two-entry {pixel, weight} skid buffer; the parent guarantees it never pushes while full.
module seq_skid_buffer
    import classifier_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_push,
    input  logic [BEAT_W-1:0] i_data,
    input  logic              i_pop,
    output logic [BEAT_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_occupancy
);

    logic [BEAT_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data      = r_mem[r_rd_ptr];
    assign o_valid     = (r_count != 2'd0);
    assign o_occupancy = r_count;

endmodule

// File: rtl/classifier_sequencer.sv
// Streams a batch of images from pixel/weight BRAMs into one classifier and collects results.
// Optional perf counters enabled by defining CLASSIFIER_SEQ_PERF_EN.
module classifier_sequencer
    import classifier_pkg::*;
#(
    parameter int unsigned NUM_FEATURES = DEF_NUM_FEATURES,
    parameter int unsigned NUM_CLASSES  = DEF_NUM_CLASSES,
    parameter int unsigned PIX_ADDR_W   = 16,
    parameter int unsigned W_ADDR_W     = $clog2(NUM_FEATURES),
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           i_start,
    input  logic [7:0]                     i_num_images,
    input  logic [PIX_ADDR_W-1:0]          i_base_addr,
    input  logic [NUM_CLASSES*CLASS_W-1:0] i_bias_in,
    output logic [PIX_ADDR_W-1:0]          o_pix_addr,
    input  logic [PIX_W-1:0]               i_pix_rdata,
    output logic [W_ADDR_W-1:0]            o_w_addr,
    input  logic [WVEC_W-1:0]              i_w_rdata,
    classifier_sequencer_if.master         cls,
    output logic [CLASS_W-1:0]             o_result_class,
    output logic [7:0]                     o_result_index,
    output logic                           o_result_valid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err,
    output logic [31:0]                    o_perf_cycles,
    output logic [31:0]                    o_perf_stalls
);

    localparam int unsigned FEAT_CNT_W = $clog2(NUM_FEATURES + 1);
    localparam int unsigned TMO_W      = $clog2(TIMEOUT + 1);
    localparam int unsigned BIAS_W     = NUM_CLASSES * CLASS_W;
    localparam logic [FEAT_CNT_W-1:0] FEAT_ALL  = FEAT_CNT_W'(NUM_FEATURES);
    localparam logic [FEAT_CNT_W-1:0] FEAT_LAST = FEAT_CNT_W'(NUM_FEATURES - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);

    seq_state_t              r_state;
    logic [7:0]              r_num_images;
    logic [7:0]              r_image_idx;
    logic [PIX_ADDR_W-1:0]   r_pix_ptr;
    logic [FEAT_CNT_W-1:0]   r_feat;
    logic [FEAT_CNT_W-1:0]   r_xfer;
    logic [TMO_W-1:0]        r_wait_cnt;
    logic [BIAS_W-1:0]       r_bias;
    logic                    r_inflight;
    logic [CLASS_W-1:0]      r_result_class;
    logic [7:0]              r_result_index;
    logic                    r_result_valid;
    logic                    r_done;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_launch;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_valid;
    logic [1:0]              w_occ;
    logic [2:0]              w_fill;
    logic [BEAT_W-1:0]       w_head;
    logic [PIX_ADDR_W-1:0]   w_rd_pix_addr;
    logic [FEAT_CNT_W-1:0]   w_rd_feat;

    assign w_accept = RST & i_start & (r_state == IDLE);
    // The first read goes out in the start cycle so beat 0 is valid two cycles later.
    assign w_launch = w_accept & (i_num_images != 8'd0);

    assign w_pop   = w_valid & cls.x_tready & cls.w_tready;
    assign w_fill  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = w_launch
                   | ((r_state == STREAM) & (r_feat != FEAT_ALL) & (w_fill < 3'd2));

    assign w_rd_pix_addr = w_launch ? i_base_addr : r_pix_ptr;
    assign w_rd_feat     = w_launch ? '0 : r_feat;
    assign o_pix_addr    = w_rd_pix_addr;
    assign o_w_addr      = w_rd_feat[W_ADDR_W-1:0];

    seq_skid_buffer u_skid (
        .CLK         (CLK),
        .RST         (RST),
        .i_push      (r_inflight),
        .i_data      ({i_pix_rdata, i_w_rdata}),
        .i_pop       (w_pop),
        .o_data      (w_head),
        .o_valid     (w_valid),
        .o_occupancy (w_occ)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state        <= IDLE;
            r_num_images   <= 8'd0;
            r_image_idx    <= 8'd0;
            r_pix_ptr      <= '0;
            r_feat         <= '0;
            r_xfer         <= '0;
            r_wait_cnt     <= '0;
            r_bias         <= '0;
            r_inflight     <= 1'b0;
            r_result_class <= '0;
            r_result_index <= 8'd0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            r_inflight     <= w_issue;
            if (w_issue) begin
                r_pix_ptr <= w_rd_pix_addr + 1'b1;
                r_feat    <= w_rd_feat + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_num_images <= i_num_images;
                        r_bias       <= i_bias_in;
                        r_err        <= 1'b0;
                        r_image_idx  <= 8'd0;
                        r_xfer       <= '0;
                        r_state      <= (i_num_images == 8'd0) ? FINISH : STREAM;
                    end
                end
                STREAM: begin
                    if (w_pop) begin
                        if (r_xfer == FEAT_LAST) begin
                            r_xfer     <= '0;
                            r_wait_cnt <= '0;
                            r_state    <= WAIT_RES;
                        end else begin
                            r_xfer <= r_xfer + 1'b1;
                        end
                    end
                end
                WAIT_RES: begin
                    // A result arriving on the expiry cycle still wins over the timeout.
                    if (cls.a_tvalid) begin
                        r_result_class <= cls.a_tdata;
                        r_result_index <= r_image_idx;
                        r_result_valid <= 1'b1;
                        r_state        <= NEXT;
                    end else if (r_wait_cnt == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (r_image_idx == r_num_images - 8'd1) begin
                        r_state <= FINISH;
                    end else begin
                        r_image_idx <= r_image_idx + 8'd1;
                        r_feat      <= '0;
                        r_state     <= STREAM;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cls.x_tdata  = w_head[BEAT_W-1:WVEC_W];
    assign cls.w_tdata  = w_head[WVEC_W-1:0];
    assign cls.x_tvalid = w_valid;
    assign cls.w_tvalid = w_valid;
    assign cls.b_tdata  = r_bias;
    assign cls.b_tvalid = (r_state == STREAM) | (r_state == WAIT_RES);
    assign cls.a_tready = (r_state == WAIT_RES);

    assign o_result_class = r_result_class;
    assign o_result_index = r_result_index;
    assign o_result_valid = r_result_valid;
    assign o_busy         = (r_state != IDLE);
    assign o_done         = r_done;
    assign o_err          = r_err;

`ifdef CLASSIFIER_SEQ_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_perf_cycles <= 32'd0;
            r_perf_stalls <= 32'd0;
        end else if (w_accept) begin
            r_perf_cycles <= 32'd0;
            r_perf_stalls <= 32'd0;
        end else begin
            if (o_busy) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (w_valid & ~w_pop) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign o_perf_cycles = r_perf_cycles;
    assign o_perf_stalls = r_perf_stalls;
`else
    assign o_perf_cycles = 32'd0;
    assign o_perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_classifier_sequencer.sv
// Directed batches with random data/stalls, checked against a contiguous-address beat model.
module tb_classifier_sequencer;

    localparam int unsigned NF  = 160;
    localparam int unsigned PAW = 16;
    localparam int unsigned WAW = $clog2(NF);
    localparam int unsigned TMO = 1024;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic            i_start;
    logic [7:0]      i_num_images;
    logic [PAW-1:0]  i_base_addr;
    logic [39:0]     i_bias_in;
    logic [PAW-1:0]  o_pix_addr;
    logic [3:0]      i_pix_rdata;
    logic [WAW-1:0]  o_w_addr;
    logic [39:0]     i_w_rdata;
    logic [3:0]      o_result_class;
    logic [7:0]      o_result_index;
    logic            o_result_valid;
    logic            o_busy;
    logic            o_done;
    logic            o_err;
    logic [31:0]     o_perf_cycles;
    logic [31:0]     o_perf_stalls;

    classifier_sequencer_if #(.BIAS_W(40)) cls ();

    classifier_sequencer #(
        .NUM_FEATURES (NF),
        .NUM_CLASSES  (10),
        .PIX_ADDR_W   (PAW),
        .W_ADDR_W     (WAW),
        .TIMEOUT      (TMO)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .i_start        (i_start),
        .i_num_images   (i_num_images),
        .i_base_addr    (i_base_addr),
        .i_bias_in      (i_bias_in),
        .o_pix_addr     (o_pix_addr),
        .i_pix_rdata    (i_pix_rdata),
        .o_w_addr       (o_w_addr),
        .i_w_rdata      (i_w_rdata),
        .cls            (cls),
        .o_result_class (o_result_class),
        .o_result_index (o_result_index),
        .o_result_valid (o_result_valid),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_perf_cycles  (o_perf_cycles),
        .o_perf_stalls  (o_perf_stalls)
    );

    logic [3:0]  pixmem [65536];
    logic [39:0] wmem   [256];

    always @(posedge CLK) begin
        i_pix_rdata <= pixmem[o_pix_addr];
        i_w_rdata   <= wmem[o_w_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},   64'({o_pix_addr, o_w_addr}), 64'(0));
        check({tag, "_stream"}, 64'({cls.x_tvalid, cls.w_tvalid, cls.x_tdata, cls.w_tdata}), 64'(0));
        check({tag, "_bias"},   64'({cls.b_tvalid, cls.b_tdata, cls.a_tready}), 64'(0));
        check({tag, "_status"}, 64'({o_result_class, o_result_index, o_result_valid,
                                     o_busy, o_done, o_err}), 64'(0));
        check({tag, "_perf"},   64'({o_perf_cycles, o_perf_stalls}), 64'(0));
    endtask

    // n images from base; stall_pct = % chance each ready is low; respond=0 never returns a
    // result; cls_val<0 picks random classes; abort_at>=0 pulses reset after that many beats.
    task automatic run_batch(input int n, input int base, input int stall_pct, input bit respond,
                             input int cls_val, input int abort_at, input string name);
        logic [39:0] bias;
        logic [3:0]  exp_cls [$];
        logic [3:0]  pend;
        int c, xfers, results, dones, done_c, post;
        int first_valid, first_x, last_x, tready_cycles, wait_cyc, resp_delay;
        bit xr, wr;
        bias = {8'($urandom), 32'($urandom)};
        c = 0; xfers = 0; results = 0; dones = 0; done_c = -1; post = 0;
        first_valid = -1; first_x = -1; last_x = -1; tready_cycles = 0; wait_cyc = 0;
        resp_delay = $urandom_range(5);
        i_start = 1'b1;
        i_num_images = 8'(n);
        i_base_addr = PAW'(base);
        i_bias_in = bias;
        @(negedge CLK);
        i_start = 1'b0;
        i_num_images = 8'($urandom);
        i_base_addr = PAW'($urandom);
        i_bias_in = {8'($urandom), 32'($urandom)};
        while (c < 6000 && post < 3) begin
            c++;
            if (abort_at >= 0 && xfers == abort_at) begin
                cls.x_tready = 1'b0;
                cls.w_tready = 1'b0;
                cls.a_tvalid = 1'b0;
                RST = 1'b0;
                @(negedge CLK);
                check_all_zero({name, "_midrst"});
                RST = 1'b1;
                @(negedge CLK);
                return;
            end
            if (c == 1) begin
                check({name, "_err_cleared"}, 64'(o_err), 64'(0));
                check({name, "_busy_after_start"}, 64'(o_busy), 64'(1));
            end
            i_start = (c == 10);
            if (o_result_valid === 1'b1) begin
                if (exp_cls.size() == 0) begin
                    check({name, "_unexpected_result"}, 64'(results), 64'(-1));
                end else begin
                    pend = exp_cls.pop_front();
                    check({name, "_result_class"}, 64'(o_result_class), 64'(pend));
                end
                check({name, "_result_index"}, 64'(o_result_index), 64'(results));
                results++;
            end
            if (o_done === 1'b1) begin
                dones++;
                if (done_c < 0) done_c = c;
                check({name, "_busy_at_done"}, 64'(o_busy), 64'(0));
            end
            if (cls.x_tvalid === 1'b1 && first_valid < 0) first_valid = c;
            xr = int'($urandom_range(99)) >= stall_pct;
            wr = int'($urandom_range(99)) >= stall_pct;
            cls.x_tready = xr;
            cls.w_tready = wr;
            if (cls.x_tvalid === 1'b1) begin
                // Whatever is presented must be the next beat of the contiguous stream.
                check({name, "_beat_x"}, 64'(cls.x_tdata), 64'(pixmem[PAW'(base + xfers)]));
                check({name, "_beat_w"}, 64'(cls.w_tdata), 64'(wmem[xfers % NF]));
                check({name, "_bias"}, 64'({cls.b_tvalid, cls.w_tvalid, cls.b_tdata}),
                      64'({2'b11, bias}));
                if (xr && wr) begin
                    if (first_x < 0) first_x = c;
                    last_x = c;
                    xfers++;
                end
            end
            if (cls.a_tready === 1'b1) begin
                tready_cycles++;
                if (respond && wait_cyc == resp_delay) begin
                    pend = (cls_val >= 0) ? 4'(cls_val) : 4'($urandom_range(9));
                    cls.a_tvalid = 1'b1;
                    cls.a_tdata = pend;
                    exp_cls.push_back(pend);
                end else begin
                    cls.a_tvalid = 1'b0;
                end
                wait_cyc++;
            end else begin
                wait_cyc = 0;
                resp_delay = $urandom_range(5);
                cls.a_tvalid = respond ? 1'($urandom_range(1)) : 1'b0;
                cls.a_tdata = 4'($urandom);
            end
            if (dones > 0) post++;
            @(negedge CLK);
        end
        i_start = 1'b0;
        cls.x_tready = 1'b0;
        cls.w_tready = 1'b0;
        cls.a_tvalid = 1'b0;
        check({name, "_finished"}, 64'(post), 64'(3));
        check({name, "_xfers"}, 64'(xfers), 64'(n * NF));
        check({name, "_results"}, 64'(results), 64'(respond ? n : 0));
        check({name, "_done_once"}, 64'(dones), 64'(1));
        check({name, "_err_final"}, 64'(o_err), 64'(!respond && n > 0));
        check({name, "_busy_final"}, 64'(o_busy), 64'(0));
        if (n == 0) begin
            check({name, "_done_latency"}, 64'(done_c), 64'(2));
            check({name, "_no_valid"}, 64'(first_valid), 64'(-1));
        end
        if (!respond) begin
            check({name, "_timeout_cycles"}, 64'(tready_cycles), 64'(TMO));
        end
        if (stall_pct == 0 && n == 1) begin
            check({name, "_first_valid"}, 64'(first_valid), 64'(2));
            check({name, "_throughput"}, 64'(last_x - first_x), 64'(NF - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) pixmem[i] = 4'($urandom);
        for (int i = 0; i < 256; i++) wmem[i] = {8'($urandom), 32'($urandom)};
        i_start = 1'b0;
        i_num_images = 8'd0;
        i_base_addr = '0;
        i_bias_in = '0;
        cls.x_tready = 1'b0;
        cls.w_tready = 1'b0;
        cls.a_tvalid = 1'b0;
        cls.a_tdata = 4'd0;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b1;
        @(negedge CLK);

        run_batch(1, 0, 0, 1'b1, 7, -1, "single");
        run_batch(2, int'($urandom_range(60000)), 30, 1'b1, -1, -1, "stall30");
        run_batch(3, 100, 10, 1'b1, -1, -1, "three");
        run_batch(0, 5, 0, 1'b1, -1, -1, "zero");
        run_batch(1, 65500, 0, 1'b0, -1, -1, "timeout_wrap");
        run_batch(1, 20, 20, 1'b1, -1, -1, "err_clear");
        run_batch(2, 300, 0, 1'b1, -1, 50, "abort");
        run_batch(1, 300, 0, 1'b1, -1, -1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
